lift_ctrl: RTL

Parametrised multi-request elevator controller for the lift subsystem. Latches floor calls into a pending-request bitmap and serves them in SCAN order (keep direction while calls remain ahead, then reverse). Models per-floor travel time and door dwell with internal counters, and reports car position, motion and door state to the panel/indicator logic.

---
 rtl/lift_pkg.sv | 38 +++
 rtl/lift_req_scan.sv | 62 ++++++
 rtl/lift_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lift_pkg.sv
// -----------------------------------------------------------------------------
// lift_pkg
// Shared definitions for the lift controller slice:
//   - lift_state_e   : controller state enumeration (IDLE, MOVE, DOOR_OPEN)
//   - IDLE/MOVE/DOOR_OPEN : the same encodings as plain logic constants, used
//                      as the FSM state register values
//   - DIR_UP/DIR_DOWN: direction-memory encodings
//   - tmr_width()    : width of a down/up counter able to hold the larger of
//                      the travel and dwell periods
// -----------------------------------------------------------------------------
package lift_pkg;

    typedef enum logic [1:0] {
        LIFT_IDLE      = 2'd0,
        LIFT_MOVE      = 2'd1,
        LIFT_DOOR_OPEN = 2'd2
    } lift_state_e;

    localparam logic [1:0] IDLE      = LIFT_IDLE;
    localparam logic [1:0] MOVE      = LIFT_MOVE;
    localparam logic [1:0] DOOR_OPEN = LIFT_DOOR_OPEN;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // One shared timer serves both travel and dwell, so it must hold the
    // larger period (the dwell counter is loaded with DOOR_CYC itself).
    function automatic int tmr_width(input int travel_cyc, input int door_cyc);
        int max_v;
        max_v = (travel_cyc > door_cyc) ? travel_cyc : door_cyc;
        if (max_v < 1) begin
            return 1;
        end else begin
            return $clog2(max_v + 1);
        end
    endfunction

endpackage : lift_pkg

// File: rtl/lift_req_scan.sv
// -----------------------------------------------------------------------------
// lift_req_scan
// Combinational SCAN look-ahead: reports whether any pending call lies
// strictly beyond the given floor in the travel direction (ahead) or strictly
// beyond it in the opposite direction (behind). The floor itself counts as
// neither.
// Ports:
//   pending_i  [NUM_FLOORS] outstanding-call bitmap
//   floor_i    [FLOOR_W]    reference floor
//   dir_up_i   [1]          direction memory (1 = up)
//   ahead_o    [1]          a call exists beyond floor_i in dir_up_i direction
//   behind_o   [1]          a call exists beyond floor_i in the other direction
// -----------------------------------------------------------------------------
module lift_req_scan
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]    floor_i,
    input  logic                  dir_up_i,
    output logic                  ahead_o,
    output logic                  behind_o
);

    logic [NUM_FLOORS-1:0] above_s;
    logic [NUM_FLOORS-1:0] below_s;
    logic                  any_above_s;
    logic                  any_below_s;

    // Masks of floors strictly above / strictly below the reference floor.
    always_comb begin
        above_s = '0;
        below_s = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (FLOOR_W'(i) > floor_i) begin
                above_s[i] = 1'b1;
            end else if (FLOOR_W'(i) < floor_i) begin
                below_s[i] = 1'b1;
            end else begin
                above_s[i] = 1'b0;
                below_s[i] = 1'b0;
            end
        end
    end

    assign any_above_s = |(pending_i & above_s);
    assign any_below_s = |(pending_i & below_s);

    // Map above/below onto ahead/behind according to the direction memory.
    always_comb begin
        if (dir_up_i == DIR_UP) begin
            ahead_o  = any_above_s;
            behind_o = any_below_s;
        end else begin
            ahead_o  = any_below_s;
            behind_o = any_above_s;
        end
    end

endmodule : lift_req_scan

// File: rtl/lift_ctrl.sv
// -----------------------------------------------------------------------------
// lift_ctrl
// Single-car elevator controller. Floor calls are latched into a pending
// bitmap and served in SCAN order: keep the current direction while calls
// remain ahead, then reverse. Travel time per floor and door dwell are
// modelled by one internal timer.
// Optional feature macro: LIFT_ESTOP_EN adds the estop input (freezes
// travel/dwell timers; car reports stopped, door state unchanged).
// Ports:
//   clk        [1]          clock, rising edge
//   reset_n    [1]          asynchronous active-low reset
//   req_valid  [1]          floor call present this cycle
//   req_floor  [FLOOR_W]    requested floor, values >= NUM_FLOORS ignored
//   estop      [1]          emergency stop (only with LIFT_ESTOP_EN)
//   floor      [FLOOR_W]    current car floor
//   up/down    [1]          car moving up / down
//   door       [1]          door open
//   stop       [1]          car stationary
//   arrived    [1]          one-cycle pulse when the door opens for a call
//   pending    [NUM_FLOORS] outstanding-call bitmap
// -----------------------------------------------------------------------------
module lift_ctrl
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
`ifdef LIFT_ESTOP_EN
    input  logic                  estop,
`endif
    output logic [FLOOR_W-1:0]    floor,
    output logic                  up,
    output logic                  down,
    output logic                  door,
    output logic                  stop,
    output logic                  arrived,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int                 TMR_W       = tmr_width(TRAVEL_CYC, DOOR_CYC);
    localparam logic [TMR_W-1:0]   TRAVEL_LAST = TMR_W'(TRAVEL_CYC - 1);
    localparam logic [TMR_W-1:0]   DOOR_LOAD   = TMR_W'(DOOR_CYC);
    localparam logic [TMR_W-1:0]   TMR_ONE     = TMR_W'(1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] BOT_FLOOR   = '0;

    // State registers and their next-state values
    logic [1:0]            state_q,   state_d;
    logic [FLOOR_W-1:0]    floor_q,   floor_d;
    logic                  dir_up_q,  dir_up_d;
    logic [TMR_W-1:0]      timer_q,   timer_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic                  arrived_q, arrived_d;
    logic                  up_q,      up_d;
    logic                  down_q,    down_d;
    logic                  door_q,    door_d;
    logic                  stop_q,    stop_d;

    logic                  estop_s;
    logic                  req_in_range_s;
    logic                  door_hit_s;
    logic                  req_take_s;
    logic                  at_limit_s;
    logic [FLOOR_W-1:0]    step_floor_s;
    logic [FLOOR_W-1:0]    scan_floor_s;
    logic                  ahead_s;
    logic                  behind_s;
    logic [NUM_FLOORS-1:0] cur_onehot_s;
    logic [NUM_FLOORS-1:0] step_onehot_s;
    logic [NUM_FLOORS-1:0] set_mask_s;
    logic [NUM_FLOORS-1:0] clr_mask_s;
    logic                  pend_here_s;
    logic                  pend_step_s;
    logic                  clr_en_s;
    logic [FLOOR_W-1:0]    clr_floor_s;

`ifdef LIFT_ESTOP_EN
    assign estop_s = estop;
`else
    assign estop_s = 1'b0;
`endif

    // Zero-extend before comparing so NUM_FLOORS == 2**FLOOR_W does not wrap.
    assign req_in_range_s = ({1'b0, req_floor} < (FLOOR_W + 1)'(NUM_FLOORS));
    // A call for the floor the door is already open at only extends the dwell.
    assign door_hit_s     = req_valid && req_in_range_s &&
                            (state_q == DOOR_OPEN) && (req_floor == floor_q);
    assign req_take_s     = req_valid && req_in_range_s && !door_hit_s;

    // Floor the car will reach on the next travel step; pinned at the ends.
    always_comb begin
        if (dir_up_q == DIR_UP) begin
            at_limit_s = (floor_q == TOP_FLOOR);
        end else begin
            at_limit_s = (floor_q == BOT_FLOOR);
        end
        if (at_limit_s) begin
            step_floor_s = floor_q;
        end else if (dir_up_q == DIR_UP) begin
            step_floor_s = floor_q + FLOOR_W'(1);
        end else begin
            step_floor_s = floor_q - FLOOR_W'(1);
        end
    end

    // While moving, decisions are taken about the floor being arrived at;
    // otherwise about the floor the car is standing at.
    assign scan_floor_s = (state_q == MOVE) ? step_floor_s : floor_q;

    lift_req_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan (
        .pending_i  (pending_q),
        .floor_i    (scan_floor_s),
        .dir_up_i   (dir_up_q),
        .ahead_o    (ahead_s),
        .behind_o   (behind_s)
    );

    // One-hot decodes of the current and next floors and of the call.
    always_comb begin
        cur_onehot_s  = '0;
        step_onehot_s = '0;
        set_mask_s    = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            cur_onehot_s[i]  = (floor_q == FLOOR_W'(i));
            step_onehot_s[i] = (step_floor_s == FLOOR_W'(i));
            set_mask_s[i]    = req_take_s && (req_floor == FLOOR_W'(i));
        end
    end

    assign pend_here_s = |(pending_q & cur_onehot_s);
    assign pend_step_s = |(pending_q & step_onehot_s);

    // SCAN state machine: next state, floor, direction, timer, arrival pulse.
    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        dir_up_d    = dir_up_q;
        timer_d     = timer_q;
        arrived_d   = 1'b0;
        clr_en_s    = 1'b0;
        clr_floor_s = floor_q;
        case (state_q)
            IDLE: begin
                if (estop_s) begin
                    state_d = IDLE;
                end else if (pend_here_s) begin
                    state_d     = DOOR_OPEN;
                    timer_d     = DOOR_LOAD;
                    arrived_d   = 1'b1;
                    clr_en_s    = 1'b1;
                    clr_floor_s = floor_q;
                end else if (ahead_s) begin
                    state_d = MOVE;
                    timer_d = '0;
                end else if (behind_s) begin
                    state_d  = MOVE;
                    dir_up_d = !dir_up_q;
                    timer_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            MOVE: begin
                if (estop_s) begin
                    timer_d = timer_q;
                end else if (timer_q >= TRAVEL_LAST) begin
                    timer_d = '0;
                    floor_d = step_floor_s;
                    if (pend_step_s) begin
                        state_d     = DOOR_OPEN;
                        timer_d     = DOOR_LOAD;
                        arrived_d   = 1'b1;
                        clr_en_s    = 1'b1;
                        clr_floor_s = step_floor_s;
                    end else if (ahead_s) begin
                        state_d = MOVE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            DOOR_OPEN: begin
                if (door_hit_s) begin
                    timer_d = DOOR_LOAD;
                end else if (estop_s) begin
                    timer_d = timer_q;
                end else if (timer_q <= TMR_ONE) begin
                    timer_d = '0;
                    if (ahead_s) begin
                        state_d = MOVE;
                    end else if (behind_s) begin
                        state_d  = MOVE;
                        dir_up_d = !dir_up_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                timer_d  = '0;
                dir_up_d = DIR_UP;
            end
        endcase
    end

    // Clear mask for the floor being served this cycle.
    always_comb begin
        clr_mask_s = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            clr_mask_s[i] = clr_en_s && (clr_floor_s == FLOOR_W'(i));
        end
    end

    // Clear is applied after set so a call for the floor being served is
    // absorbed by that service.
    assign pending_d = (pending_q | set_mask_s) & ~clr_mask_s;

    // Output decode from next state so the indicators are registered.
    always_comb begin
        if ((state_d == MOVE) && !estop_s) begin
            up_d   = dir_up_d;
            down_d = !dir_up_d;
        end else begin
            up_d   = 1'b0;
            down_d = 1'b0;
        end
        stop_d = !(up_d || down_d);
        door_d = (state_d != MOVE);
    end

    // Sequential state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            dir_up_q  <= DIR_UP;
            timer_q   <= '0;
            pending_q <= '0;
            arrived_q <= 1'b0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            door_q    <= 1'b1;
            stop_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_up_q  <= dir_up_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            arrived_q <= arrived_d;
            up_q      <= up_d;
            down_q    <= down_d;
            door_q    <= door_d;
            stop_q    <= stop_d;
        end
    end

    assign floor   = floor_q;
    assign up      = up_q;
    assign down    = down_q;
    assign door    = door_q;
    assign stop    = stop_q;
    assign arrived = arrived_q;
    assign pending = pending_q;

endmodule : lift_ctrl
